// File: rtl/full_adder_bist.sv
// On-chip exerciser for a 1-bit full adder: walks {a,b,cin} through 0..7,
// lets each vector settle, checks sum/carry and records errors and the first failing vector.
module full_adder_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_cin,
    input  logic             dut_sum,
    input  logic             dut_carry_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("full_adder_bist: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_e;

    state_e           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [2:0]       ffvec_q, ffvec_d;
    logic [2:0]       dut_q, dut_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic exp_sum, exp_carry, mismatch, running;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvec_d   = ffvec_q;
        exp_sum   = ^vec_q;
        exp_carry = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
        mismatch  = (dut_sum != exp_sum) || (dut_carry_out != exp_carry);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                end
            end
            WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        running = (state_d == WAIT) || (state_d == CHECK);
        busy_d  = running;
        done_d  = (state_d == DONE);
        dut_d   = running ? vec_d : 3'd0;
        if (state_d != DONE)      pass_d = 1'b0;
        else if (state_q == DONE) pass_d = pass_q;
        else                      pass_d = (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            dut_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            dut_q   <= dut_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign {dut_a, dut_b, dut_cin} = dut_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
